// File: rtl/chunk_accum_if.sv
// rtl/chunk_accum_if.sv - issue/tree/result signal bundle for chunk_accum.
// master = issuer, tree and consumer side; slave = chunk_accum.
interface chunk_accum_if #(
  parameter int NBitsIn  = 16,
  parameter int NBitsOut = 24
);
  logic                       issue_valid_in;
  logic                       issue_last_in;
  logic                       issue_ready_out;
  logic signed [NBitsIn-1:0]  sum_in;
  logic signed [NBitsOut-1:0] out_data;
  logic                       out_sat;
  logic                       out_valid;
  logic                       out_ready_in;

  modport master (
    output issue_valid_in, issue_last_in, sum_in, out_ready_in,
    input  issue_ready_out, out_data, out_sat, out_valid
  );

  modport slave (
    input  issue_valid_in, issue_last_in, sum_in, out_ready_in,
    output issue_ready_out, out_data, out_sat, out_valid
  );
endinterface

// File: rtl/chunk_accum.sv
// rtl/chunk_accum.sv - saturating row accumulator behind the adder tree,
// with a valid/last delay line, result FIFO and credit backpressure.
module chunk_accum #(
  parameter int NBitsIn     = 16,
  parameter int NBitsOut    = 24,
  parameter int TreeLatency = 3,
  parameter int OutDepth    = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  chunk_accum_if.slave bus
);
  localparam int PtrW = (OutDepth > 1) ? $clog2(OutDepth) : 1;
  localparam int CntW = $clog2(OutDepth + 1);
  localparam int CrW  = $clog2(OutDepth + TreeLatency + 1) + 1;
  localparam logic [PtrW-1:0] PtrLast = PtrW'(OutDepth - 1);
  localparam logic signed [NBitsOut:0] MaxV = {2'b00, {(NBitsOut-1){1'b1}}};
  localparam logic signed [NBitsOut:0] MinV = {2'b11, {(NBitsOut-1){1'b0}}};

  logic [TreeLatency-1:0]     dl_v;
  logic [TreeLatency-1:0]     dl_l;
  logic                       tap_v;
  logic                       tap_l;
  logic                       fire;

  logic signed [NBitsOut-1:0] acc;
  logic                       sticky;
  logic signed [NBitsOut:0]   acc_ext;
  logic signed [NBitsOut:0]   sum_ext;
  logic signed [NBitsOut:0]   nxt;
  logic signed [NBitsOut-1:0] clamped;
  logic                       sat;

  logic signed [NBitsOut-1:0] mem_data [OutDepth];
  logic                       mem_sat  [OutDepth];
  logic [PtrW-1:0]            wr_ptr;
  logic [PtrW-1:0]            rd_ptr;
  logic [CntW-1:0]            count;
  logic                       push;
  logic                       pop;

  logic [CrW-1:0]             inflight;
  logic [CrW-1:0]             credits;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  assign fire  = bus.issue_valid_in & bus.issue_ready_out;
  assign tap_v = dl_v[TreeLatency-1];
  assign tap_l = dl_l[TreeLatency-1];
  assign push  = tap_v & tap_l;
  assign pop   = (count != '0) & bus.out_ready_in;

  // Extra headroom bit lets the overflow test happen before truncation.
  assign acc_ext = {acc[NBitsOut-1], acc};
  assign sum_ext = {{(NBitsOut + 1 - NBitsIn){bus.sum_in[NBitsIn-1]}}, bus.sum_in};

  always_comb begin
    nxt     = acc_ext + sum_ext;
    clamped = nxt[NBitsOut-1:0];
    sat     = 1'b0;
    if (nxt > MaxV) begin
      clamped = MaxV[NBitsOut-1:0];
      sat     = 1'b1;
    end else if (nxt < MinV) begin
      clamped = MinV[NBitsOut-1:0];
      sat     = 1'b1;
    end
  end

  // Every last chunk still in the tree already owns a FIFO slot, including
  // the one at the tap that is being pushed this cycle.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < TreeLatency; i++) begin
      inflight = inflight + CrW'(dl_l[i]);
    end
    credits = CrW'(OutDepth) - CrW'(count) - inflight;
  end

  assign bus.issue_ready_out = (credits != '0);
  assign bus.out_valid       = (count != '0);
  assign bus.out_data        = mem_data[rd_ptr];
  assign bus.out_sat         = mem_sat[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dl_v   <= '0;
      dl_l   <= '0;
      acc    <= '0;
      sticky <= 1'b0;
    end else begin
      dl_v[0] <= fire;
      dl_l[0] <= fire & bus.issue_last_in;
      for (int i = 1; i < TreeLatency; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_l[i] <= dl_l[i-1];
      end
      if (tap_v) begin
        if (tap_l) begin
          acc    <= '0;
          sticky <= 1'b0;
        end else begin
          acc    <= clamped;
          sticky <= sticky | sat;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < OutDepth; i++) begin
        mem_data[i] <= '0;
        mem_sat[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= clamped;
        mem_sat[wr_ptr]  <= sticky | sat;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + CntW'(push) - CntW'(pop);
    end
  end
endmodule

// File: tb/tb_chunk_accum.sv
// tb/tb_chunk_accum.sv - directed bench for chunk_accum; models the adder
// tree latency and drives junk on sum_in whenever no chunk is arriving.
module tb_chunk_accum;
  localparam int NI = 16;
  localparam int NO = 16;
  localparam int TL = 3;
  localparam int OD = 2;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic hv [TL];
  int   hs [TL];
  int   exp_q [$];
  int   nfire;
  int   nrecv;

  chunk_accum_if #(.NBitsIn(NI), .NBitsOut(NO)) bus ();

  chunk_accum #(
    .NBitsIn(NI), .NBitsOut(NO), .TreeLatency(TL), .OutDepth(OD)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One cycle: present inputs, clock, then shift the tree model.
  task automatic step(input logic v, input logic l, input int s, input logic rdy);
    logic fired;
    bus.issue_valid_in = v;
    bus.issue_last_in  = l;
    bus.out_ready_in   = rdy;
    bus.sum_in         = hv[TL-1] ? 16'(hs[TL-1]) : 16'(cyc * 37 + 11);
    fired              = v & bus.issue_ready_out;
    @(posedge clk_in);
    #1;
    for (int i = TL - 1; i > 0; i--) begin
      hv[i] = hv[i-1];
      hs[i] = hs[i-1];
    end
    hv[0] = fired;
    hs[0] = s;
    cyc++;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    rst_in = 1'b0;
  endtask

  task automatic drain_check(input string tag, input int exp_data, input int exp_sat);
    for (int k = 0; k < 12 && !bus.out_valid; k++) step(1'b0, 1'b0, 0, 1'b0);
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_data"}, bus.out_data, exp_data);
    check({tag, "_sat"}, bus.out_sat, exp_sat);
    step(1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic sus_observe();
    if (bus.out_valid) begin
      nrecv++;
      if (exp_q.size() == 0) check("sus_extra", 1, 0);
      else check("sus_data", bus.out_data, exp_q.pop_front());
    end
  endtask

  initial begin
    for (int i = 0; i < TL; i++) begin
      hv[i] = 1'b0;
      hs[i] = 0;
    end
    bus.issue_valid_in = 1'b0;
    bus.issue_last_in  = 1'b0;
    bus.out_ready_in   = 1'b0;
    bus.sum_in         = '0;
    do_reset();

    check("rst_ready", bus.issue_ready_out, 1);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_sat", bus.out_sat, 0);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 0, 1'b0);
    check("idle_valid", bus.out_valid, 0);

    // 100 - 30 + 5, result visible TreeLatency+1 cycles after the last issue
    step(1'b1, 1'b0, 100, 1'b0);
    step(1'b1, 1'b0, -30, 1'b0);
    step(1'b1, 1'b1, 5, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    check("row3_early", bus.out_valid, 0);
    step(1'b0, 1'b0, 0, 1'b0);
    check("row3_valid", bus.out_valid, 1);
    check("row3_data", bus.out_data, 75);
    check("row3_sat", bus.out_sat, 0);
    step(1'b0, 1'b0, 0, 1'b1);
    check("row3_popped", bus.out_valid, 0);

    step(1'b1, 1'b0, 30000, 1'b0);
    step(1'b1, 1'b0, 30000, 1'b0);
    step(1'b1, 1'b1, 1000, 1'b0);
    drain_check("sat_pos", 32767, 1);
    step(1'b1, 1'b0, -30000, 1'b0);
    step(1'b1, 1'b1, -30000, 1'b0);
    drain_check("sat_neg", -32768, 1);
    step(1'b1, 1'b1, 7, 1'b0);
    drain_check("single7", 7, 0);
    step(1'b1, 1'b1, -5, 1'b0);
    drain_check("single_neg", -5, 0);
    step(1'b1, 1'b0, 32767, 1'b0);
    step(1'b1, 1'b1, -1, 1'b0);
    drain_check("edge_nosat", 32766, 0);

    // Backpressure: only two single-chunk rows may be outstanding.
    step(1'b1, 1'b1, 11, 1'b0);
    check("bp_ready1", bus.issue_ready_out, 1);
    step(1'b1, 1'b1, 22, 1'b0);
    check("bp_ready2", bus.issue_ready_out, 0);
    step(1'b1, 1'b1, 33, 1'b0);
    step(1'b1, 1'b1, 44, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 0, 1'b0);
    check("bp_full_ready", bus.issue_ready_out, 0);
    check("bp_head", bus.out_data, 11);
    step(1'b0, 1'b0, 0, 1'b1);
    check("bp_ready_back", bus.issue_ready_out, 1);
    drain_check("bp_second", 22, 0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 0, 1'b0);
    check("bp_no_extra", bus.out_valid, 0);

    // Sustained single-chunk rows with the consumer always ready.
    nfire = 0;
    nrecv = 0;
    for (int i = 0; i < 24; i++) begin
      sus_observe();
      if (bus.issue_ready_out) begin
        exp_q.push_back(i * 1111 - 9000);
        nfire++;
      end
      step(1'b1, 1'b1, i * 1111 - 9000, 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      sus_observe();
      step(1'b0, 1'b0, 0, 1'b1);
    end
    check("sus_fires", nfire, 10);
    check("sus_count", nrecv, nfire);

    // Reset with one result buffered and two chunks of a row in flight.
    step(1'b1, 1'b1, 9, 1'b0);
    for (int k = 0; k < 12 && !bus.out_valid; k++) step(1'b0, 1'b0, 0, 1'b0);
    check("mid_buffered", bus.out_valid, 1);
    step(1'b1, 1'b0, 1, 1'b0);
    step(1'b1, 1'b0, 2, 1'b0);
    do_reset();
    check("mid_valid", bus.out_valid, 0);
    check("mid_data", bus.out_data, 0);
    check("mid_ready", bus.issue_ready_out, 1);
    step(1'b1, 1'b0, 4, 1'b0);
    step(1'b1, 1'b1, 6, 1'b0);
    drain_check("mid_row", 10, 0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 0, 1'b0);
    check("mid_no_extra", bus.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
